fpu_arbiter: RTL

//  Shares one single-issue fpu instance (op 0=add, 1=sub, IEEE-754 single) among NUM_REQ requesters.

---
 rtl/fpu_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/fpu_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared encodings for the fpu arbiter: FSM states, fpu op codes and the timeout result word.
package fpu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic        OP_ADD  = 1'b0;
    localparam logic        OP_SUB  = 1'b1;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant to the first set req bit at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] j;

    // Walk from the farthest offset to the nearest so the nearest requester wins.
    always_comb begin
        gnt = '0;
        j   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % N);
            if (req[j]) begin
                gnt = N'(1) << j;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin share of one single-issue fpu among NUM_REQ requesters, one operation in flight.
// FPU_ARB_TIMEOUT_EN adds a WAIT watchdog that answers qNaN and pulses o_timeout.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [NUM_REQ-1:0]    i_req_op,
    input  logic [32*NUM_REQ-1:0] i_req_a,
    input  logic [32*NUM_REQ-1:0] i_req_b,
    output logic [NUM_REQ-1:0]    o_rsp_valid,
    input  logic [NUM_REQ-1:0]    i_rsp_ready,
    output logic [31:0]           o_rsp_data,
    output logic [31:0]           o_fpu_data_1,
    output logic [31:0]           o_fpu_data_2,
    output logic                  o_fpu_op,
    output logic                  o_fpu_valid,
    input  logic                  i_fpu_valid,
    input  logic [31:0]           i_fpu_data,
    output logic                  o_busy
`ifdef FPU_ARB_TIMEOUT_EN
    ,
    output logic                  o_timeout
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic [31:0]          rsp_dat_q, rsp_dat_d;
    logic [31:0]          a_q, a_d, b_q, b_d;
    logic                 op_q, op_d;
    logic                 fpu_vld_q, fpu_vld_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic [31:0]          a_sel, b_sel;
    logic                 op_sel;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_q, timeout_d;
`else
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
    end
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (i_req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        a_sel   = '0;
        b_sel   = '0;
        op_sel  = OP_ADD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IW'(i);
                a_sel   = i_req_a[32*i +: 32];
                b_sel   = i_req_b[32*i +: 32];
                op_sel  = (i_req_op[i] == OP_SUB) ? OP_SUB : OP_ADD;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        rsp_vld_d = rsp_vld_q;
        rsp_dat_d = rsp_dat_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        fpu_vld_d = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    gidx_d  = gnt_idx;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    op_d    = op_sel;
                    ptr_d   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_vld_d = 1'b1;
                state_d   = ST_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (i_fpu_valid) begin
                    rsp_dat_d = i_fpu_data;
                    rsp_vld_d = NUM_REQ'(1) << gidx_q;
                    state_d   = ST_RESP;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES)) begin
                    rsp_dat_d = FP_QNAN;
                    rsp_vld_d = NUM_REQ'(1) << gidx_q;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (|(rsp_vld_q & i_rsp_ready)) begin
                    rsp_vld_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            fpu_vld_q <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            fpu_vld_q <= fpu_vld_d;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Accept is combinational so a requester is taken in the same cycle it is picked.
    assign o_req_ready  = (state_q == ST_IDLE) ? gnt : '0;
    assign o_rsp_valid  = rsp_vld_q;
    assign o_rsp_data   = rsp_dat_q;
    assign o_fpu_data_1 = a_q;
    assign o_fpu_data_2 = b_q;
    assign o_fpu_op     = op_q;
    assign o_fpu_valid  = fpu_vld_q;
    assign o_busy       = (state_q != ST_IDLE);
`ifdef FPU_ARB_TIMEOUT_EN
    assign o_timeout    = timeout_q;
`endif

endmodule
